// File: rtl/seq_mult_div_if.sv
// seq_mult_div_if: operand/result bundle between the control unit (master) and the multiply/divide unit (slave)
// Ports: op/start/a/b requests from master; hi/lo/busy/done/div0 results to master
interface seq_mult_div_if #(parameter int WIDTH = 32);
  logic [1:0]       op;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div0;
  modport master (output op, start, a, b, input hi, lo, busy, done, div0);
  modport slave (input op, start, a, b, output hi, lo, busy, done, div0);
endinterface

// File: rtl/seq_mult_div.sv
// seq_mult_div: iterative signed MULT (radix-2 Booth) / DIV (restoring) unit feeding HI/LO
// Ports: clk, reset (sync, active-high); s = slave side of seq_mult_div_if
//   s.op/s.start/s.a/s.b in; s.hi/s.lo results, s.busy, s.done pulse, s.div0 flag out
module seq_mult_div #(parameter int WIDTH = 32) (
  input logic          clk,
  input logic          reset,
  seq_mult_div_if.slave s
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;
  state_t           r_state;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_m;
  logic             r_qm1;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic             r_dz;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;
  logic             r_div0;
  logic             w_go;
  logic             w_last;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_booth;
  logic [WIDTH:0]   w_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_dif;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  // a start in the done cycle is refused even though the state is already IDLE
  assign w_go    = s.start && r_state == IDLE && !r_done && (s.op == 2'b01 || s.op == 2'b10);
  assign w_last  = r_cnt == CW'(WIDTH - 1);
  assign w_abs_a = s.a[WIDTH-1] ? -s.a : s.a;
  assign w_abs_b = s.b[WIDTH-1] ? -s.b : s.b;
  // Booth pair {q0, q-1}: 10 subtracts, 01 adds; acc carries one guard bit so MIN operands cannot overflow
  assign w_booth = (r_q[0] && !r_qm1) ? r_acc - r_m : (!r_q[0] && r_qm1) ? r_acc + r_m : r_acc;
  // restoring step: partial remainder shifted left with the next dividend bit pulled in from r_q
  assign w_sh    = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_ge    = w_sh >= r_m;
  assign w_dif   = w_sh[WIDTH-1:0] - r_m[WIDTH-1:0];
  assign w_quo   = r_neg_q ? -r_q : r_q;
  assign w_rem   = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_q      <= '0;
      r_m      <= '0;
      r_qm1    <= 1'b0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_dz     <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (w_go) begin
          r_state  <= s.op[0] ? MULT : (s.b == '0 ? FINISH : DIV);
          r_busy   <= 1'b1;
          r_div0   <= 1'b0;
          r_cnt    <= '0;
          r_is_div <= s.op[1];
          r_dz     <= s.op[1] && s.b == '0;
          r_neg_q  <= s.a[WIDTH-1] ^ s.b[WIDTH-1];
          r_neg_r  <= s.a[WIDTH-1];
          r_acc    <= '0;
          r_qm1    <= 1'b0;
          r_q      <= s.op[0] ? s.a : w_abs_a;
          r_m      <= s.op[0] ? {s.b[WIDTH-1], s.b} : {1'b0, w_abs_b};
        end
        MULT: begin
          r_acc   <= {w_booth[WIDTH], w_booth[WIDTH:1]};
          r_q     <= {w_booth[0], r_q[WIDTH-1:1]};
          r_qm1   <= r_q[0];
          r_cnt   <= r_cnt + 1'b1;
          r_state <= w_last ? FINISH : MULT;
        end
        DIV: begin
          r_acc   <= {1'b0, w_ge ? w_dif : w_sh[WIDTH-1:0]};
          r_q     <= {r_q[WIDTH-2:0], w_ge};
          r_cnt   <= r_cnt + 1'b1;
          r_state <= w_last ? FINISH : DIV;
        end
        FINISH: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_div0  <= r_dz;
          if (!r_dz) begin
            r_hi <= r_is_div ? w_rem : r_acc[WIDTH-1:0];
            r_lo <= r_is_div ? w_quo : r_q;
          end
        end
      endcase
    end
  end
  assign s.hi   = r_hi;
  assign s.lo   = r_lo;
  assign s.busy = r_busy;
  assign s.done = r_done;
  assign s.div0 = r_div0;
endmodule

// File: tb/tb_seq_mult_div.sv
// tb_seq_mult_div: table vectors, random ops against an arithmetic model, and handshake/reset corner sequences
module tb_seq_mult_div;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  seq_mult_div_if #(.WIDTH(W)) bus ();
  seq_mult_div #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .s(bus));
  int n_tests = 0;
  int n_fail = 0;
  logic [W-1:0] prev_hi = '0;
  logic [W-1:0] prev_lo = '0;
  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
    longint sa, sb, p, q, r;
    sa = $signed(a);
    sb = $signed(b);
    dz = 1'b0;
    hi = prev_hi;
    lo = prev_lo;
    if (op == 2'b01) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (sb == 0) begin
      dz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endfunction

  task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz);
    int lat;
    @(negedge clk);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk); #1;
    check({name, " busy_after_start"}, 64'(bus.busy), 64'(1));
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) break;
    end
    check({name, " latency"}, 64'(lat), 64'(edz ? 1 : W + 1));
    check({name, " hi"}, 64'(bus.hi), 64'(ehi));
    check({name, " lo"}, 64'(bus.lo), 64'(elo));
    check({name, " div0"}, 64'(bus.div0), 64'(edz));
    check({name, " busy_at_done"}, 64'(bus.busy), 64'(0));
    prev_hi = ehi;
    prev_lo = elo;
    @(posedge clk); #1;
    check({name, " done_pulse"}, 64'(bus.done), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ehi, elo, hi5, lo5;
    logic edz;
    logic [1:0] op;
    logic [W-1:0] a, b;
    int dones, lat;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset hi", 64'(bus.hi), 64'(0));
    check("reset lo", 64'(bus.lo), 64'(0));
    check("reset busy", 64'(bus.busy), 64'(0));
    check("reset done", 64'(bus.done), 64'(0));
    check("reset div0", 64'(bus.div0), 64'(0));
    @(negedge clk); reset = 1'b0;

    vecs.push_back('{2'b01, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0});
    vecs.push_back('{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0});
    vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0});
    vecs.push_back('{2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
    vecs.push_back('{2'b10, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0});
    vecs.push_back('{2'b10, 32'd5, 32'd0, 32'h00000001, 32'hFFFFFFFD, 1'b1});
    vecs.push_back('{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0});
    vecs.push_back('{2'b10, 32'h80000000, 32'h80000000, 32'h00000000, 32'h00000001, 1'b0});
    vecs.push_back('{2'b10, 32'd3, 32'd7, 32'h00000003, 32'h00000000, 1'b0});
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz);

    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.op = k == 0 ? 2'b00 : 2'b11; bus.a = 32'd9; bus.b = 32'd9; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check($sformatf("ignored_op%0d busy", k), 64'(bus.busy), 64'(0));
      @(posedge clk); #1;
      check($sformatf("ignored_op%0d done", k), 64'(bus.done), 64'(0));
      check($sformatf("ignored_op%0d lo", k), 64'(bus.lo), 64'(prev_lo));
    end

    for (int k = 0; k < 40; k++) begin
      op = 2'($urandom_range(1, 2));
      a = $urandom;
      b = (k % 4 == 3) ? 32'($signed($urandom_range(0, 20)) - 10) : $urandom;
      if (k == 10) b = '0;
      model(op, a, b, ehi, elo, edz);
      run_op($sformatf("rand%0d op%0d a=%h b=%h", k, op, a, b), op, a, b, ehi, elo, edz);
    end

    a = 32'h12345678; b = 32'hFFFFFFFB;
    model(2'b01, a, b, ehi, elo, edz);
    @(negedge clk);
    bus.op = 2'b01; bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.op = 2'b10; bus.a = 32'd5; bus.b = 32'd0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dones = 0; hi5 = '0; lo5 = '0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) begin dones++; hi5 = bus.hi; lo5 = bus.lo; end
    end
    check("start_while_busy dones", 64'(dones), 64'(1));
    check("start_while_busy hi", 64'(hi5), 64'(ehi));
    check("start_while_busy lo", 64'(lo5), 64'(elo));
    check("start_while_busy div0", 64'(bus.div0), 64'(0));
    prev_hi = ehi; prev_lo = elo;

    model(2'b01, 32'd6, 32'd7, ehi, elo, edz);
    @(negedge clk);
    bus.op = 2'b01; bus.a = 32'd6; bus.b = 32'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) break;
    end
    check("done_cycle latency", 64'(lat), 64'(W + 1));
    check("done_cycle lo", 64'(bus.lo), 64'(elo));
    prev_hi = ehi; prev_lo = elo;
    bus.op = 2'b01; bus.a = 32'd2; bus.b = 32'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("start_in_done_cycle busy", 64'(bus.busy), 64'(0));
    check("start_in_done_cycle done", 64'(bus.done), 64'(0));

    @(negedge clk);
    bus.op = 2'b10; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort busy", 64'(bus.busy), 64'(0));
    check("abort hi", 64'(bus.hi), 64'(0));
    check("abort lo", 64'(bus.lo), 64'(0));
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check("abort no_done", 64'(dones), 64'(0));
    prev_hi = '0; prev_lo = '0;
    run_op("after_abort mult", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
